// File: rtl/matrix_receiver_if.sv
// -----------------------------------------------------------------------------
// matrix_receiver_if
// Bundles the CPU matrix stream, the bank read port and the frame status of
// matrix_receiver.
//   master : CPU/consumer side (drives the stream, read select and ack)
//   slave  : the receiver (drives read data and frame status)
// Signals:
//   CPUvalid     frame-active qualifier
//   matrixState  CPU state code (0 idle, 1..6 matrix, 7 gap, 8 frame end)
//   mtrxIn       4x4 matrix, element k at [W*k +: W], k = row*4+col
//   rd_sel       bank read select (0..5, 6..7 read as zero)
//   frame_ack    one-cycle release pulse from the consumer
//   mtrx_rd      registered bank read data
//   loaded_mask  per-bank captured-this-frame flags
//   frame_ready  complete in-order frame available
//   err_seq      sticky sequence violation
//   frame_cnt    completed-frame counter (wraps)
// -----------------------------------------------------------------------------
interface matrix_receiver_if #(
    parameter int W = 21
);
    logic              CPUvalid;
    logic [3:0]        matrixState;
    logic [16*W-1:0]   mtrxIn;
    logic [2:0]        rd_sel;
    logic              frame_ack;
    logic [16*W-1:0]   mtrx_rd;
    logic [5:0]        loaded_mask;
    logic              frame_ready;
    logic              err_seq;
    logic [7:0]        frame_cnt;

    modport master (
        output CPUvalid, matrixState, mtrxIn, rd_sel, frame_ack,
        input  mtrx_rd, loaded_mask, frame_ready, err_seq, frame_cnt
    );

    modport slave (
        input  CPUvalid, matrixState, mtrxIn, rd_sel, frame_ack,
        output mtrx_rd, loaded_mask, frame_ready, err_seq, frame_cnt
    );
endinterface

// File: rtl/matrix_receiver.sv
// -----------------------------------------------------------------------------
// matrix_receiver
// Captures the six matrices (input, rotate-X/Y/Z, shifting, projection) of the
// CPU matrix stream into a six-entry bank, checks that the states arrive in
// order, flags a complete frame to the downstream multiply pipeline and serves
// the bank through a registered read port.
// Ports:
//   CLK   clock
//   rst   asynchronous, active-high reset
//   bus   matrix_receiver_if.slave (stream in, read port, frame status out)
// Parameters:
//   W            element width (Q1.10.10 signed)
//   CAPTURE_CYC  settled edges seen before a state's matrix is sampled (1..5)
// -----------------------------------------------------------------------------
module matrix_receiver #(
    parameter int W           = 21,
    parameter int CAPTURE_CYC = 2
) (
    input logic              CLK,
    input logic              rst,
    matrix_receiver_if.slave bus
);

    localparam int         MW        = 16 * W;
    localparam logic [2:0] CAP_DWELL = 3'(CAPTURE_CYC);

    logic [3:0]    state_q, state_d;
    logic [2:0]    dwell_q, dwell_d;
    logic [MW-1:0] bank_q [6];
    logic [MW-1:0] bank_d [6];
    logic [MW-1:0] mtrx_rd_q, mtrx_rd_d;
    logic [5:0]    mask_q, mask_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          same_s;
    logic          in_range_s;
    logic          capture_s;
    logic          seq_err_s;
    logic          ack_s;
    logic          set_ready_s;
    logic [2:0]    cap_idx_s;

    // Next-state logic: dwell tracking, capture, sequence check, frame status, read mux.
    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        mask_d    = mask_q;
        ready_d   = ready_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        mtrx_rd_d = '0;
        for (int i = 0; i < 6; i++) begin
            bank_d[i] = bank_q[i];
        end

        same_s     = (bus.matrixState == state_q);
        in_range_s = (bus.matrixState >= 4'd1) && (bus.matrixState <= 4'd6);
        // dwell only passes CAP_DWELL once per visit, so this fires once per state
        capture_s  = bus.CPUvalid && same_s && (dwell_q == CAP_DWELL) && in_range_s;
        cap_idx_s  = bus.matrixState[2:0] - 3'd1;
        seq_err_s  = bus.CPUvalid && !same_s &&
                     !((bus.matrixState == (state_q + 4'd1)) && (state_q <= 4'd7));
        ack_s      = bus.CPUvalid && bus.frame_ack && ready_q;
        // an illegal jump into state 8 on this very edge also blocks the frame
        set_ready_s = bus.CPUvalid && (bus.matrixState == 4'd8) && (mask_q == 6'h3F) &&
                      !err_q && !seq_err_s && !ready_q;

        // Bank write; capture is already qualified by CPUvalid
        for (int i = 0; i < 6; i++) begin
            if (capture_s && (cap_idx_s == 3'(i))) begin
                bank_d[i] = bus.mtrxIn;
            end else begin
                bank_d[i] = bank_q[i];
            end
        end

        if (!bus.CPUvalid) begin
            // partial frame discarded; bank and frame counter retained
            state_d = 4'd0;
            dwell_d = 3'd0;
            mask_d  = 6'h00;
            ready_d = 1'b0;
            err_d   = 1'b0;
            cnt_d   = cnt_q;
        end else begin
            state_d = bus.matrixState;

            if (!same_s) begin
                dwell_d = 3'd1;
            end else if (dwell_q == 3'd7) begin
                dwell_d = 3'd7;
            end else begin
                dwell_d = dwell_q + 3'd1;
            end

            if (ack_s) begin
                mask_d = 6'h00;
            end else begin
                mask_d = mask_q;
            end
            if (capture_s) begin
                mask_d = mask_d | (6'b00_0001 << cap_idx_s);
            end else begin
                mask_d = mask_d;
            end

            err_d = err_q | seq_err_s;

            if (ack_s) begin
                ready_d = 1'b0;
            end else if (set_ready_s) begin
                ready_d = 1'b1;
            end else begin
                ready_d = ready_q;
            end

            if (set_ready_s) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end

        // Read uses the pre-capture bank, so a same-edge capture returns old data
        case (bus.rd_sel)
            3'd0:    mtrx_rd_d = bank_q[0];
            3'd1:    mtrx_rd_d = bank_q[1];
            3'd2:    mtrx_rd_d = bank_q[2];
            3'd3:    mtrx_rd_d = bank_q[3];
            3'd4:    mtrx_rd_d = bank_q[4];
            3'd5:    mtrx_rd_d = bank_q[5];
            default: mtrx_rd_d = '0;
        endcase
    end

    // State, bank and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= 4'd0;
            dwell_q   <= 3'd0;
            mtrx_rd_q <= '0;
            mask_q    <= 6'h00;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
            for (int i = 0; i < 6; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            mtrx_rd_q <= mtrx_rd_d;
            mask_q    <= mask_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < 6; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign bus.mtrx_rd     = mtrx_rd_q;
    assign bus.loaded_mask = mask_q;
    assign bus.frame_ready = ready_q;
    assign bus.err_seq     = err_q;
    assign bus.frame_cnt   = cnt_q;

endmodule

// File: tb/tb_matrix_receiver.sv
// -----------------------------------------------------------------------------
// tb_matrix_receiver
// Directed bench for matrix_receiver with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_matrix_receiver;

    localparam int W  = 21;
    localparam int MW = 16 * W;

    logic CLK = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    // Free-running 100 MHz clock.
    always #5 CLK = ~CLK;

    matrix_receiver_if #(.W(W)) bus ();

    matrix_receiver #(
        .W           (W),
        .CAPTURE_CYC (2)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [MW-1:0] mk(input logic [W-1:0] e0, input logic [W-1:0] e15);
        logic [MW-1:0] m;
        m = '0;
        m[W-1:0]     = e0;
        m[15*W +: W] = e15;
        return m;
    endfunction

    // Hold state s for n edges; matrix element0 = s*0x100 + tag during 1..6.
    task automatic drive(input logic [3:0] s, input logic [W-1:0] tag, input int n);
        bus.matrixState = s;
        if ((s >= 4'd1) && (s <= 4'd6)) begin
            bus.mtrxIn = mk(W'({s, 8'h00}) + tag, 21'h100000 | W'(s));
        end else begin
            bus.mtrxIn = '0;
        end
        step(n);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] sel, input logic [W-1:0] exp0);
        bus.rd_sel = sel;
        step(1);
        chk(tag, 64'(bus.mtrx_rd[W-1:0]), 64'(exp0));
    endtask

    // Minimum-length legal frame: states 1..6 held 3 edges each.
    task automatic fast_frame(input logic [W-1:0] tag);
        bus.CPUvalid = 1'b0;
        step(1);
        bus.CPUvalid = 1'b1;
        drive(4'd0, tag, 1);
        for (int s = 1; s <= 6; s++) begin
            drive(4'(s), tag, 3);
        end
        drive(4'd7, tag, 1);
        drive(4'd8, tag, 1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.CPUvalid    = 1'b0;
        bus.matrixState = 4'd0;
        bus.mtrxIn      = '0;
        bus.rd_sel      = 3'd0;
        bus.frame_ack   = 1'b0;
        step(3);
        chk("rst_mtrx_rd", 64'(bus.mtrx_rd[63:0]), 64'd0);
        chk("rst_mask",    64'(bus.loaded_mask), 64'h00);
        chk("rst_ready",   64'(bus.frame_ready), 64'd0);
        chk("rst_err",     64'(bus.err_seq), 64'd0);
        chk("rst_cnt",     64'(bus.frame_cnt), 64'd0);
        rst = 1'b0;
        step(1);

        // Full legal frame, 7 edges per state.
        bus.CPUvalid = 1'b1;
        drive(4'd0, 21'h0, 7);
        drive(4'd1, 21'h0, 2);
        chk("cap_not_yet", 64'(bus.loaded_mask), 64'h00);
        step(1);
        chk("cap_3rd_edge", 64'(bus.loaded_mask), 64'h01);
        step(4);
        for (int s = 2; s <= 6; s++) begin
            drive(4'(s), 21'h0, 7);
        end
        chk("full_mask", 64'(bus.loaded_mask), 64'h3F);
        drive(4'd7, 21'h0, 7);
        chk("gap_ready", 64'(bus.frame_ready), 64'd0);
        drive(4'd8, 21'h0, 1);
        chk("f1_ready", 64'(bus.frame_ready), 64'd1);
        chk("f1_cnt",   64'(bus.frame_cnt), 64'd1);
        step(6);
        chk("f1_ready_hold", 64'(bus.frame_ready), 64'd1);
        chk("f1_cnt_once",   64'(bus.frame_cnt), 64'd1);
        rd_chk("rd_bank3", 3'd3, 21'h400);
        rd_chk("rd_bank0", 3'd0, 21'h100);
        chk("rd_bank0_e15", 64'(bus.mtrx_rd[15*W +: W]), 64'h100001);
        rd_chk("rd_sel6", 3'd6, 21'h0);

        // Acknowledge releases the frame; no re-arm while held at 8.
        bus.frame_ack = 1'b1;
        step(1);
        bus.frame_ack = 1'b0;
        chk("ack_ready", 64'(bus.frame_ready), 64'd0);
        chk("ack_mask",  64'(bus.loaded_mask), 64'h00);
        step(4);
        chk("ack_no_rearm", 64'(bus.frame_ready), 64'd0);
        chk("ack_cnt",      64'(bus.frame_cnt), 64'd1);

        // Capture point on state 2, plus same-edge read semantics; then jump 2->4.
        bus.CPUvalid = 1'b0;
        step(1);
        bus.CPUvalid = 1'b1;
        drive(4'd0, 21'h10, 2);
        drive(4'd1, 21'h10, 7);
        bus.matrixState = 4'd2;
        bus.rd_sel      = 3'd1;
        bus.mtrxIn      = mk(21'h0AAA, 21'h0);
        step(2);
        chk("rd_before_cap", 64'(bus.mtrx_rd[W-1:0]), 64'h200);
        bus.mtrxIn = mk(21'h0BBB, 21'h0);
        step(1);
        chk("rd_on_cap_old", 64'(bus.mtrx_rd[W-1:0]), 64'h200);
        bus.mtrxIn = mk(21'h0CCC, 21'h0);
        step(1);
        chk("cap_value_b", 64'(bus.mtrx_rd[W-1:0]), 64'hBBB);
        step(3);
        chk("late_change_ign", 64'(bus.mtrx_rd[W-1:0]), 64'hBBB);
        chk("no_err_yet", 64'(bus.err_seq), 64'd0);
        drive(4'd4, 21'h10, 7);
        chk("jump_err", 64'(bus.err_seq), 64'd1);
        for (int s = 5; s <= 8; s++) begin
            drive(4'(s), 21'h10, 7);
        end
        chk("err_ready",  64'(bus.frame_ready), 64'd0);
        chk("err_mask",   64'(bus.loaded_mask), 64'h3B);
        chk("err_cnt",    64'(bus.frame_cnt), 64'd1);
        rd_chk("cap_after_err", 3'd3, 21'h410);
        bus.CPUvalid = 1'b0;
        step(1);
        chk("drop_clr_err",  64'(bus.err_seq), 64'd0);
        chk("drop_clr_mask", 64'(bus.loaded_mask), 64'h00);

        // Mid-frame abort in state 4 (dwell 2 at the drop edge).
        bus.CPUvalid = 1'b1;
        drive(4'd0, 21'h20, 2);
        for (int s = 1; s <= 3; s++) begin
            drive(4'(s), 21'h20, 7);
        end
        chk("abort_pre_mask", 64'(bus.loaded_mask), 64'h07);
        drive(4'd4, 21'h20, 2);
        bus.CPUvalid = 1'b0;
        step(1);
        chk("abort_mask",  64'(bus.loaded_mask), 64'h00);
        chk("abort_ready", 64'(bus.frame_ready), 64'd0);
        rd_chk("abort_bank0", 3'd0, 21'h120);
        rd_chk("abort_bank1", 3'd1, 21'h220);
        rd_chk("abort_bank2", 3'd2, 21'h320);
        rd_chk("abort_bank3", 3'd3, 21'h410);

        // Short state 5 (2 edges): not captured, not an error.
        bus.CPUvalid = 1'b1;
        drive(4'd0, 21'h30, 2);
        for (int s = 1; s <= 4; s++) begin
            drive(4'(s), 21'h30, 7);
        end
        drive(4'd5, 21'h30, 2);
        for (int s = 6; s <= 8; s++) begin
            drive(4'(s), 21'h30, 7);
        end
        chk("short_mask",  64'(bus.loaded_mask), 64'h2F);
        chk("short_ready", 64'(bus.frame_ready), 64'd0);
        chk("short_err",   64'(bus.err_seq), 64'd0);
        chk("short_cnt",   64'(bus.frame_cnt), 64'd1);
        rd_chk("short_bank4", 3'd4, 21'h510);

        // Frame counter wrap: 254 more frames reach 255, the next wraps to 0.
        for (int i = 0; i < 254; i++) begin
            fast_frame(21'h40);
            bus.frame_ack = 1'b1;
            step(1);
            bus.frame_ack = 1'b0;
        end
        chk("cnt_255", 64'(bus.frame_cnt), 64'd255);
        fast_frame(21'h50);
        chk("wrap_ready", 64'(bus.frame_ready), 64'd1);
        chk("cnt_wrap",   64'(bus.frame_cnt), 64'd0);
        rd_chk("fast_bank5", 3'd5, 21'h650);
        bus.CPUvalid = 1'b0;
        step(1);
        chk("drop_clr_ready", 64'(bus.frame_ready), 64'd0);
        chk("drop_keep_cnt",  64'(bus.frame_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
